// File: rtl/alu_cnt_dec_unit.sv
// Arithmetic/decode utility block: combinational 4-bit ALU with flags,
// 3-bit wrap-around down-counter, and 3-to-8 one-hot decoder.
// Ports:
//   clk, resetn                 - system clock, async active-low reset
//   alu_fnselec, alu_a, alu_b   - ALU op select and two's complement operands
//   alu_res, alu_zero,
//   alu_overflow, alu_carry     - ALU result and flags (combinational)
//   cnt_en, cnt_q               - counter enable and registered count
//   dec_x, dec_en, dec_y        - decoder select/enable and one-hot output
module alu_cnt_dec_unit #(
  parameter logic [2:0] CNT_RST = 3'd0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] alu_fnselec,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  output logic [3:0] alu_res,
  output logic       alu_zero,
  output logic       alu_overflow,
  output logic       alu_carry,
  input  logic       cnt_en,
  output logic [2:0] cnt_q,
  input  logic [2:0] dec_x,
  input  logic       dec_en,
  output logic [7:0] dec_y
);

  localparam int unsigned ALU_W = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEC_W = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  logic [ALU_W:0]   add_sum;
  logic [ALU_W:0]   sub_sum;
  logic [CNT_W-1:0] cnt_d;

  // Carry-extended adder and subtractor (A + ~B + 1, carry=1 means no borrow)
  always_comb begin
    add_sum = {1'b0, alu_a} + {1'b0, alu_b};
    sub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + (ALU_W+1)'(1);
  end

  // ALU result and flags; flags only meaningful for add/sub
  always_comb begin
    alu_res      = '0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_fnselec)
      OP_ADD: begin
        alu_res      = add_sum[ALU_W-1:0];
        alu_carry    = add_sum[ALU_W];
        alu_overflow = (alu_a[3] == alu_b[3]) && (add_sum[3] != alu_a[3]);
      end
      OP_SUB: begin
        alu_res      = sub_sum[ALU_W-1:0];
        alu_carry    = sub_sum[ALU_W];
        alu_overflow = (alu_a[3] != alu_b[3]) && (sub_sum[3] != alu_a[3]);
      end
      OP_NOT: alu_res = ~alu_a;
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      // True signed compare; the subtractor sign bit is wrong on overflow
      OP_SLT: alu_res = {3'b000, ($signed(alu_a) < $signed(alu_b))};
      OP_EQ:  alu_res = {3'b000, (alu_a == alu_b)};
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == 4'd0);

  // Down-counter next state; 3-bit arithmetic wraps 0 -> 7 naturally
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= CNT_RST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One-hot decoder with enable
  always_comb begin
    dec_y = '0;
    if (dec_en) begin
      dec_y = DEC_W'(1) << dec_x;
    end
  end

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
module tb_alu_cnt_dec_unit;

  logic       clk;
  logic       resetn;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_res;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry;
  logic       cnt_en;
  logic [2:0] cnt_q;
  logic [2:0] dec_x;
  logic       dec_en;
  logic [7:0] dec_y;

  int errors;
  int checks;

  alu_cnt_dec_unit #(.CNT_RST(3'd0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_fnselec  (alu_fnselec),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .cnt_en       (cnt_en),
    .cnt_q        (cnt_q),
    .dec_x        (dec_x),
    .dec_en       (dec_en),
    .dec_y        (dec_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       z;
    logic       o;
    logic       c;
  } alu_vec_t;

  alu_vec_t vecs[22];

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    checks++;
    if (cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", cnt_q);
    end
    // ALU and decoder keep working while reset is held
    alu_fnselec = 3'b000; alu_a = 4'd2; alu_b = 4'd3;
    dec_en = 1'b1; dec_x = 3'd5;
    #1;
    checks++;
    if ({alu_res, alu_zero, alu_overflow, alu_carry} !== {4'd5, 3'b000}) begin
      errors++;
      $display("FAIL reset_alu: got res=%h z=%b o=%b c=%b expected res=5 z=0 o=0 c=0",
               alu_res, alu_zero, alu_overflow, alu_carry);
    end
    checks++;
    if (dec_y !== 8'h20) begin
      errors++;
      $display("FAIL reset_dec: got %h expected 20", dec_y);
    end
  endtask

  task automatic test_alu();
    vecs[0]  = '{"add_7_1",   3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"add_F_1",   3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{"add_2_3",   3'b000, 4'h2, 4'h3, 4'h5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"add_8_8",   3'b000, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{"sub_8_1",   3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{"sub_5_5",   3'b001, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{"sub_3_5",   3'b001, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"sub_7_F",   3'b001, 4'h7, 4'hF, 4'h8, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"not_C",     3'b010, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"not_F",     3'b010, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"and_C_A",   3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"or_C_A",    3'b100, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"xor_C_A",   3'b101, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"xor_5_5",   3'b101, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{"slt_m8_1",  3'b110, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{"slt_1_m8",  3'b110, 4'h1, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{"slt_7_m1",  3'b110, 4'h7, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{"slt_3_5",   3'b110, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{"eq_5_5",    3'b111, 4'h5, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{"eq_5_6",    3'b111, 4'h5, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{"and_F_F",   3'b011, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{"or_0_0",    3'b100, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 22; i++) begin
      alu_fnselec = vecs[i].sel;
      alu_a       = vecs[i].a;
      alu_b       = vecs[i].b;
      #1;
      checks++;
      if ({alu_res, alu_zero, alu_overflow, alu_carry} !==
          {vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].c}) begin
        errors++;
        $display("FAIL alu_%s: got res=%h z=%b o=%b c=%b expected res=%h z=%b o=%b c=%b",
                 vecs[i].name, alu_res, alu_zero, alu_overflow, alu_carry,
                 vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].c);
      end
    end
  endtask

  task automatic test_decoder();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    dec_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dec_x = 3'(i);
      #1;
      checks++;
      if (dec_y !== exp_tab[i]) begin
        errors++;
        $display("FAIL dec_x%0d: got %h expected %h", i, dec_y, exp_tab[i]);
      end
    end
    dec_en = 1'b0;
    dec_x  = 3'd3;
    #1;
    checks++;
    if (dec_y !== 8'h00) begin
      errors++;
      $display("FAIL dec_dis_x3: got %h expected 00", dec_y);
    end
    dec_x = 3'd7;
    #1;
    checks++;
    if (dec_y !== 8'h00) begin
      errors++;
      $display("FAIL dec_dis_x7: got %h expected 00", dec_y);
    end
  endtask

  task automatic test_counter();
    logic [2:0] seq [9];
    seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    @(negedge clk);
    resetn = 1'b1;
    cnt_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cnt_q !== seq[i]) begin
        errors++;
        $display("FAIL cnt_step%0d: got %0d expected %0d", i, cnt_q, seq[i]);
      end
    end
    // Enable low holds the value
    @(negedge clk);
    cnt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (cnt_q !== 3'd7) begin
        errors++;
        $display("FAIL cnt_hold%0d: got %0d expected 7", i, cnt_q);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    cnt_en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd6) begin
      errors++;
      $display("FAIL arst_pre: got %0d expected 6", cnt_q);
    end
    // Reset between edges takes effect immediately
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL arst_immediate: got %0d expected 0", cnt_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd0) begin
      errors++;
      $display("FAIL arst_override_en: got %0d expected 0", cnt_q);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd7) begin
      errors++;
      $display("FAIL arst_resume1: got %0d expected 7", cnt_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cnt_q !== 3'd6) begin
      errors++;
      $display("FAIL arst_resume2: got %0d expected 6", cnt_q);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    resetn      = 1'b0;
    cnt_en      = 1'b0;
    alu_fnselec = 3'b000;
    alu_a       = 4'h0;
    alu_b       = 4'h0;
    dec_x       = 3'd0;
    dec_en      = 1'b0;
    test_reset();
    test_alu();
    test_decoder();
    test_counter();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
